// File: rtl/dmem_resp_if.sv
// Core-to-data-memory port bundle: byte address, lane-aligned store data, lane mask and
// combinational read data.
interface dmem_resp_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [3:0]  amp;
   logic [31:0] rdata;

   modport master (output addr, output wdata, output we, output amp, input rdata);
   modport slave  (input addr, input wdata, input we, input amp, output rdata);
endinterface

// File: rtl/dmem_resp.sv
// Data memory with a one-entry store buffer and a combinational read bypass.
// Define DMEM_MMIO_EN to decode 0xFFFF_0000 (cycle counter) and 0xFFFF_0004 (16-bit LED register).
module dmem_resp #(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input logic        clk,
   input logic        reset,
   dmem_resp_if.slave bus
);

   localparam int unsigned AW    = $clog2(DEPTH_WORDS);
   localparam int unsigned LANES = 4;

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] idx;
      logic [31:0]   data;
      logic [3:0]    mask;
   } sb_t;

   sb_t           sb_q;
   sb_t           sb_d;
   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [AW-1:0] word_idx;
   logic          store_c;
   logic          mmio_hit;
   logic [31:0]   merged;
   logic          unused_addr;

   assign word_idx    = bus.addr[AW+1:2];
   assign store_c     = bus.we && (bus.amp != 4'b0000);
   assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};

`ifdef DMEM_MMIO_EN
   localparam int unsigned LED_W = 16;

   logic [31:0]      cnt_q;
   logic [31:0]      cnt_d;
   logic [LED_W-1:0] led_q;
   logic [LED_W-1:0] led_d;

   assign mmio_hit = (bus.addr[31:3] == 29'h1FFF_E000);

   // Counter free-runs; LED lanes 0/1 update directly at the store edge.
   always_comb begin
      cnt_d = cnt_q + 32'd1;
      led_d = led_q;
      if (store_c && mmio_hit && bus.addr[2]) begin
         if (bus.amp[0]) led_d[7:0]  = bus.wdata[7:0];
         if (bus.amp[1]) led_d[15:8] = bus.wdata[15:8];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= 32'd0;
         led_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         led_q <= led_d;
      end
   end
`else
   assign mmio_hit = 1'b0;
`endif

   // Each edge drains the current entry; a new store (outside MMIO) becomes the next entry.
   always_comb begin
      sb_d       = '0;
      sb_d.idx   = word_idx;
      sb_d.data  = bus.wdata;
      sb_d.mask  = bus.amp;
      sb_d.valid = store_c && !mmio_hit;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sb_q <= '0;
      end else begin
         sb_q <= sb_d;
      end
   end

   // Array is not reset; a valid entry only exists while reset is released.
   always_ff @(posedge clk) begin
      if (sb_q.valid) begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (sb_q.mask[i]) mem_q[sb_q.idx][8*i +: 8] <= sb_q.data[8*i +: 8];
         end
      end
   end

   // Read path: array word overlaid byte-wise with a matching buffered store.
   always_comb begin
      merged = mem_q[word_idx];
      if (reset && sb_q.valid && (sb_q.idx == word_idx)) begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (sb_q.mask[i]) merged[8*i +: 8] = sb_q.data[8*i +: 8];
         end
      end
      bus.rdata = merged;
`ifdef DMEM_MMIO_EN
      if (mmio_hit) begin
         if (!reset)           bus.rdata = 32'd0;
         else if (bus.addr[2]) bus.rdata = {16'd0, led_q};
         else                  bus.rdata = cnt_q;
      end
`endif
   end

endmodule

// File: tb/tb_dmem_resp.sv
// Randomized scoreboard bench for dmem_resp against a visible-memory reference model.
// Works with or without DMEM_MMIO_EN defined.
module tb_dmem_resp;

   localparam int unsigned DEPTH = 256;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;
   bit   done   = 0;

   exp_t sbq[$];

   // Reference state: memory as a reader sees it, plus undo info for the newest store.
   logic [31:0] vis_m [DEPTH];
   bit          pend_v = 0;
   int          bak_idx = 0;
   logic [31:0] bak_word = 32'd0;
   logic [31:0] cyc_m = 32'd0;
   logic [15:0] led_m = 16'd0;

   dmem_resp_if bus ();

   dmem_resp #(.DEPTH_WORDS(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   function automatic bit in_win(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
      return (a >= 32'hFFFF_0000) && (a <= 32'hFFFF_0007);
`else
      return (a != a);
`endif
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (in_win(a)) begin
         if (!reset) return 32'd0;
         return a[2] ? {16'd0, led_m} : cyc_m;
      end
      return vis_m[widx(a)];
   endfunction

   task automatic model_edge(input logic [31:0] a, input logic [31:0] wd,
                             input logic w, input logic [3:0] m);
      int i;
      if (!reset) return;
      pend_v = 0;
      cyc_m  = cyc_m + 32'd1;
      if (w && m != 4'd0) begin
         if (in_win(a)) begin
            if (a[2]) begin
               if (m[0]) led_m[7:0]  = wd[7:0];
               if (m[1]) led_m[15:8] = wd[15:8];
            end
         end else begin
            i        = widx(a);
            bak_idx  = i;
            bak_word = vis_m[i];
            for (int b = 0; b < 4; b++)
               if (m[b]) vis_m[i][8*b +: 8] = wd[8*b +: 8];
            pend_v = 1;
         end
      end
   endtask

   task automatic go_reset();
      reset = 1'b0;
      if (pend_v) vis_m[bak_idx] = bak_word;
      pend_v = 0;
      cyc_m  = 32'd0;
      led_m  = 16'd0;
   endtask

   // Immediate comparison of the current read data.
   task automatic check_now(input logic [31:0] exp, input string nm);
      checks = checks + 1;
      if (bus.rdata !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, bus.rdata, exp, $time);
      end
   endtask

   // One clock cycle of stimulus; optionally queues the expected read for this cycle.
   task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic w,
                        input logic [3:0] m, input bit chk, input bit use_c,
                        input logic [31:0] c, input string nm);
      exp_t e;
      bus.addr  = a;
      bus.wdata = wd;
      bus.we    = w;
      bus.amp   = m;
      if (chk) begin
         e.name = nm;
         e.exp  = use_c ? c : model_read(a);
         sbq.push_back(e);
      end
      @(posedge clk);
      model_edge(a, wd, w, m);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] c, input string nm);
      cycle(a, 32'd0, 1'b0, 4'd0, 1'b1, 1'b1, c, nm);
   endtask

   task automatic rdm(input logic [31:0] a, input string nm);
      cycle(a, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 32'd0, nm);
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
      cycle(a, wd, 1'b1, m, 1'b1, 1'b0, 32'd0, "store_cycle_read");
   endtask

   // Monitor: rdata is valid every cycle; compare away from the active edge.
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         checks = checks + 1;
         if (bus.rdata !== e.exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, bus.rdata, e.exp, $time);
         end
      end
   end

   // Watchdog: the stimulus must complete within a bounded time.
   initial begin
      #2_000_000;
      if (!done) begin
         errors = errors + 1;
         $display("FAIL watchdog: stimulus did not complete at %0t", $time);
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end

   initial begin
      logic [31:0] a;
      logic [31:0] last_a;
      bus.addr = 32'd0; bus.wdata = 32'd0; bus.we = 1'b0; bus.amp = 4'd0;
      go_reset();
      repeat (2) @(posedge clk);
      #1;
`ifdef DMEM_MMIO_EN
      rd(32'hFFFF_0000, 32'd0, "cnt_in_reset");
      rd(32'hFFFF_0004, 32'd0, "led_in_reset");
`else
      cycle(32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0, "");
`endif
      reset = 1'b1;

      // Fill the whole array so every later read has a known value.
      for (int i = 0; i < int'(DEPTH); i++)
         cycle(32'(i * 4), $urandom, 1'b1, 4'hF, 1'b0, 1'b0, 32'd0, "");
      cycle(32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0, "");

      // Full-word store: bypass next cycle, then from the array.
      st(32'h100, 32'h1122_3344, 4'hF);
      rd(32'h100, 32'h1122_3344, "sw_bypass");
      repeat (3) rdm(32'h10, "idle_read");
      rd(32'h100, 32'h1122_3344, "sw_drained");

      // Single-byte store merges into the word.
      st(32'h100, 32'h0000_AA00, 4'b0010);
      rd(32'h100, 32'h1122_AA44, "sb_merge");
      rd(32'h102, 32'h1122_AA44, "sb_merge_low_bits_ignored");

      // Back-to-back stores.
      st(32'h200, 32'h0000_000A, 4'hF);
      st(32'h204, 32'h0000_000B, 4'hF);
      rd(32'h200, 32'h0000_000A, "b2b_first");
      rd(32'h204, 32'h0000_000B, "b2b_second");

      // Same-cycle store and read.
      st(32'h300, 32'h1234_5678, 4'hF);
      rdm(32'h0, "idle_read");
      cycle(32'h300, 32'h0000_0055, 1'b1, 4'hF, 1'b1, 1'b1, 32'h1234_5678, "same_cycle_old");
      rd(32'h300, 32'h0000_0055, "same_cycle_next");

      // we with amp=0 and amp with we=0 write nothing.
      cycle(32'h300, 32'hFFFF_FFFF, 1'b1, 4'd0, 1'b1, 1'b1, 32'h55, "we_amp0");
      cycle(32'h300, 32'hFFFF_FFFF, 1'b0, 4'hF, 1'b1, 1'b1, 32'h55, "amp_we0");
      rd(32'h300, 32'h0000_0055, "no_write");

      // Reset before drain loses the buffered store.
      st(32'h400, 32'hCAFE_0000, 4'hF);
      rdm(32'h0, "idle_read");
      st(32'h400, 32'h0000_DEAD, 4'hF);
      go_reset();
      bus.addr  = 32'h400;
      bus.wdata = 32'd0;
      bus.we    = 1'b0;
      bus.amp   = 4'd0;
      #1;
      check_now(32'hCAFE_0000, "reset_state_immediate");
      rd(32'h400, 32'hCAFE_0000, "reset_raw_array");
      reset = 1'b1;
`ifdef DMEM_MMIO_EN
      rd(32'hFFFF_0000, 32'd0, "cnt_after_release");
`endif
      rd(32'h400, 32'hCAFE_0000, "reset_store_lost");
      st(32'h404, 32'h0BAD_F00D, 4'hF);
      rd(32'h404, 32'h0BAD_F00D, "store_after_release");

      // MMIO LED store (or aliased array word without MMIO).
      st(32'h4, 32'd0, 4'hF);
      st(32'hFFFF_0004, 32'h0000_BEEF, 4'b0011);
      rd(32'hFFFF_0004, 32'h0000_BEEF, "led_or_alias");
      rdm(32'hFFFF_0000, "cnt_read_a");
      rdm(32'h0, "idle_read");
      rdm(32'h0, "idle_read");
      rdm(32'hFFFF_0000, "cnt_read_b");

      // Randomized traffic with occasional resets.
      last_a = 32'h0;
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 9))
            0:       a = 32'hFFFF_0000 + 32'($urandom_range(0, 7));
            1, 2, 3: a = last_a;
            default: a = $urandom;
         endcase
         last_a = a;
         if ($urandom_range(0, 59) == 0) begin
            go_reset();
            rdm(a, "rand_in_reset");
            cycle(a, $urandom, 1'b1, 4'hF, 1'b1, 1'b0, 32'd0, "rand_store_in_reset");
            reset = 1'b1;
         end
         cycle(a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom), 1'b1, 1'b0, 32'd0, "rand");
      end
      rdm(last_a, "final_read");
      @(negedge clk);
      #1;
      done = 1;
      if (sbq.size() != 0) begin
         errors = errors + 1;
         $display("FAIL pending_expectations: %0d reads never compared", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 1024 (power of two), giving the number of 32-bit words in the data array.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 addr  input  32  byte address from the core's memory stage.
REQ-005 wdata  input  32  store data, already lane-aligned by the core.
REQ-006 we  input  1  store request, sampled each rising edge.
REQ-007 amp  input  4  byte-lane write enables; bit i enables wdata[8i+7:8i].
REQ-008 rdata  output  32  full aligned word at addr, combinational, including any pending store.

Function
REQ-009 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored; higher bits ignored (array aliases) except the MMIO window when enabled.
REQ-010 A store (we=1, amp!=0) in cycle N SHALL be captured into a one-entry store buffer (valid, index, data, lane mask) at edge N.
REQ-011 A valid buffer entry SHALL drain into the array at the next edge, updating only the masked lanes; other lanes keep their old value.
REQ-012 Back-to-back stores SHALL drain the old entry and capture the new entry on the same edge; no store is dropped and no stall exists.
REQ-013 we=1 with amp=0 SHALL be a no-op; at its edge the buffer drains and becomes invalid.
REQ-014 we=0 with any amp SHALL write nothing.
REQ-015 Read bypass: if the buffer is valid and its index equals the current word index, rdata SHALL be array data with buffered lanes replaced byte by byte.
REQ-016 A store and a read of the same address in the same cycle SHALL return pre-store data; the stored data is visible from cycle N+1.
REQ-017 Read latency SHALL be zero cycles (combinational from addr and state).

Reset
REQ-018 Asserting reset SHALL immediately clear buffer valid; a store not yet drained is lost.
REQ-019 Array contents SHALL NOT be reset.
REQ-020 rdata during reset SHALL equal raw array data (no bypass); MMIO registers SHALL read 0.
REQ-021 Reset deassertion mid-sequence SHALL accept a store on the first rising edge after release.

Configuration
REQ-022 Macro DMEM_MMIO_EN: when defined, the window 0xFFFF_0000-0xFFFF_0007 SHALL decode to MMIO and SHALL NOT touch the array or the buffer.
REQ-023 With DMEM_MMIO_EN, 0xFFFF_0000 SHALL read a free-running 32-bit cycle counter: reset to 0, +1 each edge, wraps 0xFFFF_FFFF to 0, writes ignored.
REQ-024 With DMEM_MMIO_EN, 0xFFFF_0004 SHALL be a 16-bit LED register in bits [15:0]: reset 0, written at the store edge, lanes 0/1 per amp, bits [31:16] read 0, no buffer delay.
REQ-025 Without DMEM_MMIO_EN, those addresses SHALL alias into the array per REQ-009, and no counter or LED logic SHALL exist.

Verification
REQ-026 sw 0x11223344 to 0x100 (amp=1111), then read 0x100 in the next cycle and 5 cycles later -> 0x11223344 both times (bypass, then drained).
REQ-027 Word 0x100 holds 0x11223344; sb 0x0000AA00 with amp=0010 -> read returns 0x1122AA44.
REQ-028 Back-to-back sw 0xA to 0x200 and sw 0xB to 0x204, then reads -> 0x200=0xA and 0x204=0xB.
REQ-029 Same-cycle sw 0x55 to 0x300 and read of 0x300 -> old value that cycle, 0x55 the next cycle.
REQ-030 sw 0xDEAD to 0x400, then assert reset before the next edge -> 0x400 holds its prior value; counter reads 0 after release.
REQ-031 With DMEM_MMIO_EN: sh 0x0000BEEF (amp=0011) to 0xFFFF_0004 -> reads 0x0000BEEF; two counter reads 3 cycles apart differ by 3. Without DMEM_MMIO_EN: the same store reads back from the aliased array word.
